target_gen_btb: RTL



---
 rtl/target_gen_btb.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/target_gen_btb.sv
// Execute-stage branch/jump target generator with a direct-mapped BTB.
// Fetch reads the BTB combinationally; the resolved next PC, redirect and misalign flag come out one cycle later.
module target_gen_btb #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int TAG_W   = 30 - IDX_W
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        flush,
   input  logic [31:0] f_pc,
   output logic        f_hit,
   output logic [31:0] f_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_ir,
   input  logic [31:0] ex_rs1,
   input  logic        ex_cond,
   input  logic        ex_pred_hit,
   input  logic [31:0] ex_pred_target,
   output logic        res_valid,
   output logic [31:0] res_next_pc,
   output logic        res_redirect,
   output logic        res_misalign
);

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [31:0]        tgt_q [ENTRIES];

   logic        res_valid_q, res_valid_d;
   logic [31:0] res_next_pc_q, res_next_pc_d;
   logic        res_redirect_q, res_redirect_d;
   logic        res_misalign_q, res_misalign_d;

   // Fetch-side lookup
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic [1:0]       unused_f_pc_lsb;

   assign f_idx           = f_pc[IDX_W+1:2];
   assign f_tag           = f_pc[31:IDX_W+2];
   assign unused_f_pc_lsb = f_pc[1:0];
   assign f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign f_target        = f_hit ? tgt_q[f_idx] : 32'h0;

   // Execute-side decode and target computation
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_entry_hit;
   logic [31:0]      imm_j, imm_b, imm_i;
   logic [31:0]      ex_target, ex_next_pc;
   logic             ex_taken, ex_misalign, ex_mispredict;
   logic             btb_wr, btb_clr;

   assign ex_idx       = ex_pc[IDX_W+1:2];
   assign ex_tag       = ex_pc[31:IDX_W+2];
   assign ex_entry_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   assign imm_j = {{12{ex_ir[31]}}, ex_ir[19:12], ex_ir[20], ex_ir[30:21], 1'b0};
   assign imm_b = {{20{ex_ir[31]}}, ex_ir[7], ex_ir[30:25], ex_ir[11:8], 1'b0};
   assign imm_i = {{20{ex_ir[31]}}, ex_ir[31:20]};

   always_comb begin
      ex_target = 32'h0;
      ex_taken  = 1'b0;
      case (ex_ir[6:0])
         OP_JAL: begin
            ex_target = ex_pc + imm_j;
            ex_taken  = 1'b1;
         end
         OP_JALR: begin
            ex_target = (ex_rs1 + imm_i) & ~32'h1;
            ex_taken  = 1'b1;
         end
         OP_BRANCH: begin
            ex_target = ex_pc + imm_b;
            ex_taken  = ex_cond;
         end
         default: begin
            ex_target = 32'h0;
            ex_taken  = 1'b0;
         end
      endcase
   end

   assign ex_next_pc    = ex_taken ? ex_target : (ex_pc + 32'd4);
   assign ex_misalign   = ex_taken & ex_target[1];
   assign ex_mispredict = (ex_pred_hit & ~ex_taken) |
                          (ex_taken & (~ex_pred_hit | (ex_pred_target != ex_target)));

   // Misaligned targets are never trained; a stale matching entry is dropped instead.
   assign btb_wr  = ex_valid & ex_taken & ~ex_misalign;
   assign btb_clr = ex_valid & ~btb_wr & ex_entry_hit;

   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = '0;
      end else if (btb_wr) begin
         valid_d[ex_idx] = 1'b1;
      end else if (btb_clr) begin
         valid_d[ex_idx] = 1'b0;
      end
   end

   always_comb begin
      res_valid_d    = ex_valid;
      res_next_pc_d  = ex_valid ? ex_next_pc : res_next_pc_q;
      res_redirect_d = ex_valid & ex_mispredict;
      res_misalign_d = ex_valid & ex_misalign;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         valid_q        <= '0;
         res_valid_q    <= 1'b0;
         res_next_pc_q  <= 32'h0;
         res_redirect_q <= 1'b0;
         res_misalign_q <= 1'b0;
      end else begin
         valid_q        <= valid_d;
         res_valid_q    <= res_valid_d;
         res_next_pc_q  <= res_next_pc_d;
         res_redirect_q <= res_redirect_d;
         res_misalign_q <= res_misalign_d;
      end
   end

   // Payload needs no reset: it is only observed through a set valid bit.
   always_ff @(posedge CLK) begin
      if (btb_wr) begin
         tag_q[ex_idx] <= ex_tag;
         tgt_q[ex_idx] <= ex_target;
      end
   end

   assign res_valid    = res_valid_q;
   assign res_next_pc  = res_next_pc_q;
   assign res_redirect = res_redirect_q;
   assign res_misalign = res_misalign_q;

endmodule
